// File: rtl/line_delay.sv
// line_delay: one-line pixel delay through a circular buffer, q is the same column one line earlier
module line_delay #(
    parameter int N      = 24,
    parameter int H_SIZE = 1280
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic         valid,
    output logic         eol
);
    localparam int AW = $clog2(H_SIZE);
    localparam int FW = $clog2(H_SIZE + 1);
    localparam logic [AW-1:0] LAST = AW'(H_SIZE - 1);
    localparam logic [FW-1:0] FULL = FW'(H_SIZE);
    logic [N-1:0]  mem [H_SIZE];
    logic [AW-1:0] wp      = '0;
    logic [FW-1:0] fill    = '0;
    logic [N-1:0]  q_r     = '0;
    logic          valid_r = 1'b0;
    logic          eol_r   = 1'b0;
    logic          full;
    assign full  = fill == FULL;
    assign q     = q_r;
    assign valid = valid_r;
    assign eol   = eol_r;
    // pixel store has no reset so it stays block RAM; stale words are masked by fill
    always_ff @(posedge clk)
        if (rst_n && ce) mem[wp] <= d;
    // pointer, fill count and registered outputs; the old word is read before the write lands
    always_ff @(posedge clk)
        if (!rst_n) begin
            wp      <= '0;
            fill    <= '0;
            q_r     <= '0;
            valid_r <= 1'b0;
            eol_r   <= 1'b0;
        end else begin
            eol_r <= ce && wp == LAST;
            if (ce) begin
                wp      <= wp == LAST ? '0 : wp + 1'b1;
                q_r     <= full ? mem[wp] : '0;
                valid_r <= full;
                if (!full) fill <= fill + 1'b1;
            end
        end
endmodule

// File: tb/tb_line_delay.sv
// tb_line_delay: randomized scoreboard bench for a small (8x4) and a full-size (24x1280) line delay
module tb_line_delay;
    localparam int H0 = 4;
    localparam int H1 = 1280;

    typedef struct packed {
        logic [23:0] q;
        logic        v;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rn0 = 1'b0, ce0 = 1'b0;
    logic [7:0]  d0  = '0;
    logic [7:0]  q0;
    logic        v0, e0;
    logic        rn1 = 1'b0, ce1 = 1'b0;
    logic [23:0] d1  = '0;
    logic [23:0] q1;
    logic        v1, e1;

    int total = 0;
    int bad   = 0;

    exp_t        expq0[$];
    exp_t        expq1[$];
    logic [23:0] hist0[$];
    logic [23:0] hist1[$];
    int          cnt[2];
    logic [23:0] lq[2];
    logic        lv[2];

    always #5 clk = ~clk;

    line_delay #(.N(8), .H_SIZE(H0)) dut0 (
        .clk(clk), .rst_n(rn0), .ce(ce0), .d(d0), .q(q0), .valid(v0), .eol(e0)
    );

    line_delay #(.N(24), .H_SIZE(H1)) dut1 (
        .clk(clk), .rst_n(rn1), .ce(ce1), .d(d1), .q(q1), .valid(v1), .eol(e1)
    );

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, want, $time);
        end
    endtask

    // Reference: a line is the list of pixels accepted since reset; once more than
    // H are held, each new pixel releases the one accepted H pixels earlier.
    task automatic step(input int id, input bit r, input bit c, input logic [23:0] dv);
        int   h;
        logic [23:0] dm;
        exp_t ex;
        h  = id == 0 ? H0 : H1;
        dm = id == 0 ? {16'h0, dv[7:0]} : dv;
        @(negedge clk);
        if (id == 0) begin rn0 = r; ce0 = c; d0 = dv[7:0]; end
        else begin rn1 = r; ce1 = c; d1 = dv; end
        @(posedge clk);
        ex.e = 1'b0;
        if (!r) begin
            if (id == 0) hist0.delete(); else hist1.delete();
            cnt[id] = 0;
            lq[id]  = '0;
            lv[id]  = 1'b0;
        end else if (c) begin
            cnt[id]++;
            if (id == 0) hist0.push_back(dm); else hist1.push_back(dm);
            if ((id == 0 ? hist0.size() : hist1.size()) > h) begin
                lq[id] = id == 0 ? hist0.pop_front() : hist1.pop_front();
                lv[id] = 1'b1;
            end else begin
                lq[id] = '0;
                lv[id] = 1'b0;
            end
            ex.e = cnt[id] % h == 0;
        end
        ex.q = lq[id];
        ex.v = lv[id];
        if (id == 0) expq0.push_back(ex); else expq1.push_back(ex);
    endtask

    // Monitor: every cycle the DUT presents a response, pop the matching expectation
    always @(negedge clk) begin
        exp_t ex;
        if (expq0.size() > 0) begin
            ex = expq0.pop_front();
            chk("small_q", {16'h0, q0}, ex.q);
            chk("small_valid", {23'h0, v0}, {23'h0, ex.v});
            chk("small_eol", {23'h0, e0}, {23'h0, ex.e});
        end
        if (expq1.size() > 0) begin
            ex = expq1.pop_front();
            chk("big_q", q1, ex.q);
            chk("big_valid", {23'h0, v1}, {23'h0, ex.v});
            chk("big_eol", {23'h0, e1}, {23'h0, ex.e});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        cnt[0] = 0; cnt[1] = 0;
        lq[0] = '0; lq[1] = '0;
        lv[0] = 1'b0; lv[1] = 1'b0;
        // continuous stream 1,2,3,... : first output on 5th edge, eol after 4, 8, 12
        step(0, 0, 0, 0);
        for (int i = 1; i <= 14; i++) step(0, 1, 1, 24'(i));
        // alternating ce with 10,20,30,... : outputs hold across idle cycles
        step(0, 0, 0, 0);
        for (int i = 1; i <= 12; i++) begin
            step(0, 1, 1, 24'(10 * i));
            step(0, 1, 0, 24'($urandom));
        end
        // mid-line reset: pre-reset pixels must never reappear
        for (int i = 0; i < 6; i++) step(0, 1, 1, 24'(200 + i));
        step(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 1, 24'(100 + i));
        // reset coinciding with ce: the pixel is not counted
        step(0, 0, 1, 24'd77);
        for (int i = 0; i < 9; i++) step(0, 1, 1, 24'(50 + i));
        // random traffic with occasional resets
        for (int i = 0; i < 300; i++)
            step(0, $urandom_range(0, 39) != 0, $urandom_range(0, 2) != 0, 24'($urandom));
        // full-size line: three lines plus a bit of random data with random gaps
        step(1, 0, 0, 0);
        acc = 0;
        while (acc < 3 * H1 + 40) begin
            bit c;
            c = $urandom_range(0, 3) != 0;
            step(1, 1, c, 24'($urandom));
            if (c) acc++;
        end
        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/line_delay.md
LINE_DELAY -- requirements
Module: line_delay

Interface
REQ-001 The block SHALL have parameter N, default 24, meaning the pixel data width in bits.
REQ-002 The block SHALL have parameter H_SIZE, default 1280, meaning the line length in pixels; legal range 2..4096.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-005 The block SHALL have port ce, input, 1 bit, the pixel-qualifying clock enable.
REQ-006 The block SHALL have port d, input, N bits, the incoming pixel.
REQ-007 The block SHALL have port q, output, N bits, the pixel from the same column one line earlier.
REQ-008 The block SHALL have port valid, output, 1 bit; high when q holds real delayed data.
REQ-009 The block SHALL have port eol, output, 1 bit, a one-cycle end-of-line pulse.

Function
REQ-010 Storage SHALL be an H_SIZE x N circular buffer, inferable as block RAM, with one write pointer wp of width clog2(H_SIZE).
REQ-011 Each write SHALL read the same location in the same cycle, read-before-write.
REQ-012 A fill counter SHALL count accepted pixels and saturate at H_SIZE.
REQ-013 On a clk edge with rst_n=1 and ce=1, wp SHALL advance: wp+1, or 0 when wp=H_SIZE-1.
REQ-014 On that same edge, d SHALL be written to mem[wp].
REQ-015 On that same edge, if fill=H_SIZE, q SHALL load the old mem[wp] and valid SHALL load 1.
REQ-016 On that same edge, if fill<H_SIZE, q SHALL load 0, valid SHALL load 0, and fill SHALL increment.
REQ-017 Latency: for the k-th accepted pixel d_k (k>H_SIZE), q SHALL equal d_(k-H_SIZE) one clk after that edge.
REQ-018 Latency SHALL be counted in ce-qualified cycles, not clk cycles.
REQ-019 On an edge with ce=0, wp, fill, mem, q and valid SHALL hold, and eol SHALL go 0.
REQ-020 eol SHALL be registered and SHALL be 1 for exactly one clk after an accepted pixel written at wp=H_SIZE-1; otherwise 0.
REQ-021 eol SHALL be independent of valid and SHALL also pulse during the first line.
REQ-022 Wrap-around: after wp=H_SIZE-1, the next write SHALL go to address 0 with no lost or duplicated pixel.
REQ-023 Back-to-back ce=1 at every clk SHALL be sustained indefinitely with no stall.
REQ-024 The block SHALL not output X: before the first full line, q SHALL be 0 regardless of uninitialised memory.

Reset
REQ-025 While rst_n=0 at a clk edge, the block SHALL set wp=0, fill=0, q=0, valid=0, eol=0; rst_n SHALL take priority over ce.
REQ-026 Reset SHALL not clear the memory; stale contents SHALL be masked by fill until a full new line is written.
REQ-027 A reset mid-line SHALL restart alignment at column 0; the first post-reset pixel SHALL be treated as column 0.
REQ-028 Power-up register values SHALL equal the reset values.

Verification
REQ-029 Scenario 1: N=8, H_SIZE=4, rst_n pulse then ce=1 continuously with d=1,2,3,... -> valid=0 and q=0 for the first 4 edges; then q=1,2,3,... with valid=1 from the 5th edge on.
REQ-030 Scenario 2: same setup -> eol high one clk after pixels 4, 8, 12; low elsewhere.
REQ-031 Scenario 3: ce toggling 1,0,1,0 with d=10,20,30,... on ce cycles -> q=10 appears on the 5th ce edge; q, valid and wp are unchanged across ce=0 cycles.
REQ-032 Scenario 4: stream 6 pixels, assert rst_n=0 for 1 clk, then stream 100,101,... -> valid=0 and q=0 for 4 ce edges, then q=100; no pre-reset data ever appears.
REQ-033 Scenario 5: rst_n=0 and ce=1 on the same edge -> reset wins; wp=0, fill=0, and d is not counted.
REQ-034 Scenario 6: H_SIZE=1280, N=24, random data over 3 lines with random ce gaps -> a scoreboard confirms q equals the pixel 1280 accepted pixels earlier, for every accepted pixel after the first line.
